gshare_pht: RTL

// Parametrised gshare direction predictor: PHT of saturating counters indexed by PC xor speculative GHR.

---
 rtl/bp_pkg.sv | 34 +++
 rtl/bp_ckpt_pipe.sv | 38 +++
 rtl/gshare_pht.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and helpers for the gshare branch predictor
// Pipe entries are sized for the widest supported configuration; instances slice what they need.
package bp_pkg;

   localparam int MAX_INDEX_BITS = 16;
   localparam int MAX_GHR_BITS   = 16;
   localparam int MAX_CTR_BITS   = 8;

   typedef struct packed {
      logic                      valid;
      logic [MAX_INDEX_BITS-1:0] idx;
      logic                      pred;
      logic [MAX_GHR_BITS-1:0]   ckpt;
   } pipe_entry_t;

   function automatic int num_pht_entries(input int index_bits);
      return 2 ** index_bits;
   endfunction

   // Saturating up/down step of a ctr_bits-wide counter held in the low bits of ctr.
   function automatic logic [MAX_CTR_BITS-1:0] sat_update(
      input logic [MAX_CTR_BITS-1:0] ctr,
      input logic                    inc,
      input int                      ctr_bits
   );
      logic [MAX_CTR_BITS-1:0] ctr_max;
      ctr_max = MAX_CTR_BITS'((64'd1 << ctr_bits) - 64'd1);
      if (inc) begin
         return (ctr == ctr_max) ? ctr : ctr + MAX_CTR_BITS'(1);
      end
      return (ctr == '0) ? ctr : ctr - MAX_CTR_BITS'(1);
   endfunction

endpackage

// File: rtl/bp_ckpt_pipe.sv
// rtl/bp_ckpt_pipe.sv - in-flight branch checkpoint shift register
// Advances only when advance is high; kill drops every valid bit on an advancing cycle.
module bp_ckpt_pipe
   import bp_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_i,
   input  logic        advance,
   input  logic        kill,
   input  pipe_entry_t entry_in,
   output pipe_entry_t tail
);

   pipe_entry_t stage [DEPTH];

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         for (int k = 0; k < DEPTH; k++) begin
            stage[k] <= '0;
         end
      end else if (advance) begin
         stage[0] <= entry_in;
         for (int k = 1; k < DEPTH; k++) begin
            stage[k] <= stage[k-1];
         end
         if (kill) begin
            for (int k = 0; k < DEPTH; k++) begin
               stage[k].valid <= 1'b0;
            end
         end
      end
   end

   assign tail = stage[DEPTH-1];

endmodule

// File: rtl/gshare_pht.sv
// rtl/gshare_pht.sv - gshare direction predictor with speculative history and checkpoint repair
// Fetch looks up and shifts history; the oldest in-flight branch trains its counter on resolution.
module gshare_pht
   import bp_pkg::*;
#(
   parameter int INDEX_BITS = 5,
   parameter int GHR_BITS   = 5,
   parameter int CTR_BITS   = 2,
   parameter int CTR_INIT   = 0,
   parameter int UPDATE_LAT = 2
) (
   input  logic                clk,
   input  logic                reset_i,
   input  logic                stall_i,
   input  logic                flush_i,
   input  logic [31:0]         pc_i,
   input  logic                branch_i,
   input  logic                resolve_valid_i,
   input  logic                resolve_taken_i,
   output logic                predict_taken_o,
   output logic                mispredict_o,
   output logic [GHR_BITS-1:0] ghr_o
);

   localparam int NUM_PHT_ENTRIES = num_pht_entries(INDEX_BITS);

   logic [CTR_BITS-1:0]   pht [NUM_PHT_ENTRIES];
   logic [GHR_BITS-1:0]   ghr_spec;
   logic [GHR_BITS-1:0]   ghr_commit;
   logic [GHR_BITS-1:0]   ghr_spec_next;
   logic [GHR_BITS-1:0]   ghr_commit_next;
   logic [GHR_BITS-1:0]   res_hist;
   logic [INDEX_BITS-1:0] idx;
   logic [INDEX_BITS-1:0] tail_idx;
   logic [GHR_BITS-1:0]   tail_ckpt;
   logic [CTR_BITS-1:0]   ctr_next;
   logic                  advance;
   logic                  res;
   logic                  mispredict;
   logic                  shift_en;
   logic                  kill;
   pipe_entry_t           entry_in;
   pipe_entry_t           tail;
   logic                  unused_bits;

   assign advance = ~stall_i;

   // History is zero-extended to the index width before hashing with the PC.
   assign idx             = pc_i[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_spec);
   assign predict_taken_o = pht[idx][CTR_BITS-1];

   assign tail_idx   = tail.idx[INDEX_BITS-1:0];
   assign tail_ckpt  = tail.ckpt[GHR_BITS-1:0];
   assign res        = resolve_valid_i & advance & tail.valid;
   assign mispredict = res & (resolve_taken_i != tail.pred);
   assign shift_en   = branch_i & advance & ~flush_i & ~mispredict;
   assign kill       = mispredict | flush_i;

   // The cast drops the oldest bit, which also covers a single-bit history.
   assign res_hist = GHR_BITS'({tail_ckpt, resolve_taken_i});
   assign ctr_next = CTR_BITS'(sat_update(MAX_CTR_BITS'(pht[tail_idx]), resolve_taken_i, CTR_BITS));

   always_comb begin
      entry_in       = '0;
      entry_in.valid = branch_i & ~flush_i & ~mispredict;
      entry_in.idx   = MAX_INDEX_BITS'(idx);
      entry_in.pred  = predict_taken_o;
      entry_in.ckpt  = MAX_GHR_BITS'(ghr_spec);
   end

   bp_ckpt_pipe #(
      .DEPTH(UPDATE_LAT)
   ) u_pipe (
      .clk      (clk),
      .reset_i  (reset_i),
      .advance  (advance),
      .kill     (kill),
      .entry_in (entry_in),
      .tail     (tail)
   );

   always_comb begin
      ghr_commit_next = res ? res_hist : ghr_commit;
      ghr_spec_next   = ghr_spec;
      if (mispredict) begin
         ghr_spec_next = res_hist;
      end else if (flush_i & advance) begin
         ghr_spec_next = ghr_commit_next;
      end else if (shift_en) begin
         ghr_spec_next = GHR_BITS'({ghr_spec, predict_taken_o});
      end
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         ghr_spec   <= '0;
         ghr_commit <= '0;
      end else begin
         ghr_spec   <= ghr_spec_next;
         ghr_commit <= ghr_commit_next;
      end
   end

   // No bypass: a lookup of the entry being trained sees the old value this cycle.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < NUM_PHT_ENTRIES; i++) begin
            pht[i] <= CTR_BITS'(CTR_INIT);
         end
      end else if (res) begin
         pht[tail_idx] <= ctr_next;
      end
   end

   assign mispredict_o = mispredict;
   assign ghr_o        = ghr_spec;

   assign unused_bits = ^{tail, pc_i};

endmodule
